// File: rtl/barrel_arbiter_if.sv
// Requester, shifter and response bundle for barrel_arbiter.
// master = arbiter side, slave = requesters/shifter/consumer side.
interface barrel_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int DW   = 32,
  parameter int CW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*CW-1:0] req_cmd;
  logic [DW-1:0]      sh_a;
  logic [CW-1:0]      sh_cmd;
  logic [DW-1:0]      sh_o;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic [IDW-1:0]     rsp_id;

  modport master (
    input  req_valid, req_a, req_cmd, sh_o, rsp_ready,
    output req_ready, sh_a, sh_cmd, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    output req_valid, req_a, req_cmd, sh_o, rsp_ready,
    input  req_ready, sh_a, sh_cmd, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/barrel_arbiter.sv
// Round-robin sharing of one external barrel shifter among NREQ requesters.
// Define BARREL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module barrel_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int DW   = 32,
  parameter int CW   = 8
) (
  input  logic clk,
  input  logic rst_n,
  barrel_arbiter_if.master bus,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [DW-1:0]  a_q, a_d;
  logic [CW-1:0]  cmd_q, cmd_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic [IDW-1:0] gnt;
  logic [IDW-1:0] cand;
  logic           found;
  logic           any_req;
  logic           accept;

`ifdef BARREL_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDW'(i);
      if (bus.req_valid[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end
`else
  // Scan upward from the slot after the last winner, wrapping at NREQ.
  always_comb begin
    gnt   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end
`endif

  assign any_req = |bus.req_valid;
  assign accept  = any_req &&
                   ((state_q == IDLE) ||
                    (state_q == RESP && bus.rsp_ready));

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[gnt] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    a_d         = a_q;
    cmd_d       = cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
        if (accept) begin
          a_d     = bus.req_a[gnt*DW +: DW];
          cmd_d   = bus.req_cmd[gnt*CW +: CW];
          id_d    = gnt;
          last_d  = gnt;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = bus.sh_o;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      a_q         <= a_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.sh_a      = a_q;
  assign bus.sh_cmd    = cmd_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_barrel_arbiter.sv
// Directed bench for barrel_arbiter with an adder standing in for the shifter.
// Define BARREL_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_barrel_arbiter;

  logic clk;
  logic rst_n;
  logic busy;
  int   tests;
  int   fails;

  logic [31:0] a_v [4];
  logic [7:0]  c_v [4];

  barrel_arbiter_if #(.NREQ(4), .IDW(2), .DW(32), .CW(8)) bus ();

  barrel_arbiter #(.NREQ(4), .IDW(2), .DW(32), .CW(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  assign bus.sh_o    = bus.sh_a + {24'h0, bus.sh_cmd};
  assign bus.req_a   = {a_v[3], a_v[2], a_v[1], a_v[0]};
  assign bus.req_cmd = {c_v[3], c_v[2], c_v[1], c_v[0]};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  // Accept cycle, EXEC cycle, then first RESP cycle for requester id.
  task automatic serve(input int id);
    logic [3:0]  oh;
    logic [31:0] exp_d;
    oh    = 4'b0001 << id;
    exp_d = a_v[id] + {24'h0, c_v[id]};
    #1;
    chk("grant", 64'(bus.req_ready), 64'(oh));
    step();
    chk("exec_valid", 64'(bus.rsp_valid), 64'(1'b0));
    chk("exec_busy", 64'(busy), 64'(1'b1));
    chk("exec_sh_a", 64'(bus.sh_a), 64'(a_v[id]));
    chk("exec_sh_cmd", 64'(bus.sh_cmd), 64'(c_v[id]));
    step();
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
    chk("rsp_id", 64'(bus.rsp_id), 64'(id));
    chk("rsp_data", 64'(bus.rsp_data), 64'(exp_d));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    a_v[0] = 32'h1000_0000; c_v[0] = 8'h01;
    a_v[1] = 32'h0000_0010; c_v[1] = 8'h03;
    a_v[2] = 32'h2000_0200; c_v[2] = 8'h05;
    a_v[3] = 32'h3000_0300; c_v[3] = 8'h07;

    // Reset state
    #12;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_sh_a", 64'(bus.sh_a), 64'(32'h0));
    chk("rst_sh_cmd", 64'(bus.sh_cmd), 64'(8'h0));
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'(32'h0));
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'(2'd0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(4'b0000));
    #3;
    rst_n = 1'b1;
    step();

    // 1: single request from requester 1
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    #1;
    chk("t1_grant", 64'(bus.req_ready), 64'(4'b0010));
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("t1_exec_busy", 64'(busy), 64'(1'b1));
    chk("t1_exec_valid", 64'(bus.rsp_valid), 64'(1'b0));
    chk("t1_sh_a", 64'(bus.sh_a), 64'(32'h0000_0010));
    chk("t1_sh_cmd", 64'(bus.sh_cmd), 64'(8'h03));
    chk("t1_no_ready", 64'(bus.req_ready), 64'(4'b0000));
    step();
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
    chk("t1_rsp_data", 64'(bus.rsp_data), 64'(32'h0000_0013));
    chk("t1_rsp_id", 64'(bus.rsp_id), 64'(2'd1));
    step();
    chk("t1_done_valid", 64'(bus.rsp_valid), 64'(1'b0));
    chk("t1_done_busy", 64'(busy), 64'(1'b0));

    // 2: all four valid, round-robin from reset
    do_reset();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) serve(n % 4);
    bus.req_valid = 4'b0000;
    step();
    chk("t2_idle", 64'(busy), 64'(1'b0));

    // 3: backpressure while serving requester 2
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    serve(2);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_valid", 64'(bus.rsp_valid), 64'(1'b1));
      chk("t3_data", 64'(bus.rsp_data), 64'(32'h2000_0205));
      chk("t3_id", 64'(bus.rsp_id), 64'(2'd2));
      chk("t3_sh_a", 64'(bus.sh_a), 64'(32'h2000_0200));
      chk("t3_sh_cmd", 64'(bus.sh_cmd), 64'(8'h05));
      chk("t3_no_ready", 64'(bus.req_ready), 64'(4'b0000));
      step();
    end
    bus.rsp_ready = 1'b1;
    serve(3);

    // 4: back-to-back from RESP with only requester 3
    bus.req_valid = 4'b1000;
    serve(3);
    bus.req_valid = 4'b0000;
    step();
    chk("t4_idle", 64'(busy), 64'(1'b0));

    // 5: reset during EXEC for requester 2
    bus.req_valid = 4'b0100;
    #1;
    chk("t5_grant", 64'(bus.req_ready), 64'(4'b0100));
    step();
    bus.req_valid = 4'b0000;
    chk("t5_exec_sh_a", 64'(bus.sh_a), 64'(32'h2000_0200));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus.rsp_valid), 64'(1'b0));
    chk("t5_rst_busy", 64'(busy), 64'(1'b0));
    chk("t5_rst_sh_a", 64'(bus.sh_a), 64'(32'h0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    chk("t5_no_rsp", 64'(bus.rsp_valid), 64'(1'b0));
    chk("t5_no_data", 64'(bus.rsp_data), 64'(32'h0));
    bus.req_valid = 4'b0101;
    serve(0);
    bus.req_valid = 4'b0000;
    step();

    // 6: requesters 0 and 3 held valid
    do_reset();
    bus.req_valid = 4'b1001;
    bus.rsp_ready = 1'b1;
`ifdef BARREL_ARB_FIXED_PRIO_EN
    serve(0);
    serve(0);
    serve(0);
`else
    serve(0);
    serve(3);
    serve(0);
`endif
    bus.req_valid = 4'b1000;
    serve(3);
    bus.req_valid = 4'b0000;
    step();
    chk("t6_idle", 64'(busy), 64'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
